// File: rtl/tcm_dump_pkg.sv
// Shared types and constants for the TCM-to-UART dump path.
// Holds the FSM state encoding and the baud counter width helper.
package tcm_dump_pkg;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_REQ   = 3'd1;
    localparam logic [2:0] S_RD_WAIT  = 3'd2;
    localparam logic [2:0] S_WAIT_CTS = 3'd3;
    localparam logic [2:0] S_TX_START = 3'd4;
    localparam logic [2:0] S_TX_DATA  = 3'd5;
    localparam logic [2:0] S_TX_STOP  = 3'd6;
    localparam logic [2:0] S_NEXT     = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE     = S_IDLE,
        ST_RD_REQ   = S_RD_REQ,
        ST_RD_WAIT  = S_RD_WAIT,
        ST_WAIT_CTS = S_WAIT_CTS,
        ST_TX_START = S_TX_START,
        ST_TX_DATA  = S_TX_DATA,
        ST_TX_STOP  = S_TX_STOP,
        ST_NEXT     = S_NEXT
    } state_e;

    localparam int UART_DATA_BITS = 8;
    localparam int BYTES_PER_WORD = 4;

    // Width of a counter that must reach baud_div-1; never narrower than 1 bit.
    function automatic int clog2_baud(input int baud_div);
        int w;
        w = 1;
        while ((1 << w) < baud_div) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/tcm_uart_dump_if.sv
// Synchronous one-cycle-latency TCM read port used by the dump engine.
// The dump engine is the master; the TCM (or its model) is the slave.
interface tcm_uart_dump_if #(
    parameter int ADDR_W = 14
) ();
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_rdata);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serialiser: start bit, 8 data bits LSB first, stop bit.
// ready_o also rises in the last stop-bit clock so frames can run back to back.
module uart_tx_byte
    import tcm_dump_pkg::*;
#(
    parameter int BAUD_DIV = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       txd_o
);
    localparam int             BW        = clog2_baud(BAUD_DIV);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [2:0]     BIT_LAST  = 3'(UART_DATA_BITS - 1);

    typedef enum logic [1:0] {PH_IDLE, PH_START, PH_DATA, PH_STOP} phase_e;

    phase_e         phase_q, phase_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           txd_q, txd_d;
    logic           bit_end;

    assign bit_end = (baud_q == BAUD_LAST);
    assign ready_o = (phase_q == PH_IDLE) || ((phase_q == PH_STOP) && bit_end);
    assign txd_o   = txd_q;

    always_comb begin
        phase_d = phase_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        baud_d  = (phase_q == PH_IDLE || bit_end) ? '0 : baud_q + 1'b1;
        case (phase_q)
            PH_START: if (bit_end) begin
                phase_d = PH_DATA;
                txd_d   = shift_q[0];
            end
            PH_DATA: if (bit_end) begin
                if (bit_q == BIT_LAST) begin
                    phase_d = PH_STOP;
                    txd_d   = 1'b1;
                end else begin
                    bit_d   = bit_q + 1'b1;
                    shift_d = shift_q >> 1;
                    txd_d   = shift_q[1];
                end
            end
            PH_STOP: if (bit_end) begin
                phase_d = PH_IDLE;
                txd_d   = 1'b1;
            end
            default: ;
        endcase
        // A new byte overrides the stop-bit exit so the next start bit follows directly.
        if (valid_i && ready_o) begin
            phase_d = PH_START;
            baud_d  = '0;
            bit_d   = '0;
            shift_d = data_i;
            txd_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q <= PH_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            phase_q <= phase_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end
endmodule

// File: rtl/tcm_uart_dump.sv
// Reads a block of TCM words and streams them out little-endian as UART 8N1 bytes.
// Owns memory reads, byte selection and CTS gating; uart_tx_byte owns the bit timing.
//
//  state       | meaning
//  ------------+-----------------------------------------------------------
//  IDLE        | waiting for start_i (also hosts the done_o cycle)
//  RD_REQ      | mem_req asserted for the current word
//  RD_WAIT     | read data arrives; byte0 launched at once if CTS allows
//  WAIT_CTS    | next byte held until cts_n_i is low
//  TX_START    | first clock of a launched frame
//  TX_DATA     | frame of byte0..2 in flight; next byte launched on ready
//  TX_STOP     | frame of byte3 in flight
//  NEXT        | advance word index; finish or read the next word
module tcm_uart_dump
    import tcm_dump_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int BAUD_DIV = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   nwords_i,
    input  logic              cts_n_i,
    tcm_uart_dump_if.master   mem,
    output logic              txd_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam logic [1:0] BYTE_LAST = 2'(BYTES_PER_WORD - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   nwords_q, nwords_d;
    logic [ADDR_W:0]   word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_q, word_d;
    logic              done_q, done_d;
    logic              tx_valid, tx_ready;
    logic [7:0]        tx_data;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        nwords_d   = nwords_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        done_d     = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = word_q[7:0];
        case (state_q)
            ST_IDLE: if (start_i && !done_q) begin
                addr_d     = base_addr_i;
                nwords_d   = nwords_i;
                word_idx_d = '0;
                if (nwords_i == '0) done_d  = 1'b1;
                else                state_d = ST_RD_REQ;
            end
            ST_RD_REQ: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                byte_idx_d = '0;
                word_d     = mem.mem_rdata;
                // Launching straight from the read data saves the WAIT_CTS cycle.
                if (!cts_n_i) begin
                    tx_valid = 1'b1;
                    tx_data  = mem.mem_rdata[7:0];
                    word_d   = {8'h00, mem.mem_rdata[31:8]};
                    state_d  = ST_TX_START;
                end else begin
                    state_d = ST_WAIT_CTS;
                end
            end
            ST_WAIT_CTS: if (!cts_n_i) begin
                tx_valid = 1'b1;
                word_d   = {8'h00, word_q[31:8]};
                state_d  = ST_TX_START;
            end
            ST_TX_START: state_d = (byte_idx_q == BYTE_LAST) ? ST_TX_STOP : ST_TX_DATA;
            ST_TX_DATA: if (tx_ready) begin
                byte_idx_d = byte_idx_q + 1'b1;
                if (!cts_n_i) begin
                    tx_valid = 1'b1;
                    word_d   = {8'h00, word_q[31:8]};
                    state_d  = ST_TX_START;
                end else begin
                    state_d = ST_WAIT_CTS;
                end
            end
            ST_TX_STOP: if (tx_ready) state_d = ST_NEXT;
            ST_NEXT: begin
                word_idx_d = word_idx_q + 1'b1;
                if (word_idx_d == nwords_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_RD_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            nwords_q   <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            nwords_q   <= nwords_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            done_q     <= done_d;
        end
    end

    // busy_o stays high through the done_o cycle so a start there is ignored.
    assign busy_o       = (state_q != ST_IDLE) || done_q;
    assign done_o       = done_q;
    assign mem.mem_req  = (state_q == ST_RD_REQ);
    assign mem.mem_addr = addr_q;

    uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (tx_valid),
        .data_i  (tx_data),
        .ready_o (tx_ready),
        .txd_o   (txd_o)
    );
endmodule

// File: tb/tb_tcm_uart_dump.sv
// Directed bench for tcm_uart_dump: sync RAM model, cycle-exact UART receiver,
// read-strobe monitor, one task per scenario.
module tb_tcm_uart_dump;
    localparam int ADDR_W = 14;
    localparam int B      = 4;
    localparam int FRAME  = 10 * B;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base = '0;
    logic [ADDR_W:0]   nwords = '0;
    logic              cts_n = 1'b0;
    logic              txd, busy, done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0]       ram [0:16383];
    logic [7:0]        rx_byte [$];
    int                rx_cyc  [$];
    bit                rx_ok   [$];
    logic [ADDR_W-1:0] req_addr [$];
    int                req_cyc  [$];
    logic [7:0]        exp_b [8];

    logic       rx_v;
    logic [7:0] rx_b;
    bit         rx_good;
    int         rx_s;

    tcm_uart_dump_if #(.ADDR_W(ADDR_W)) mem ();

    tcm_uart_dump #(.ADDR_W(ADDR_W), .BAUD_DIV(B)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base),
        .nwords_i(nwords), .cts_n_i(cts_n), .mem(mem),
        .txd_o(txd), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (mem.mem_req) mem.mem_rdata <= ram[mem.mem_addr];

    always @(negedge clk) begin
        if (!rst && mem.mem_req === 1'b1) begin
            req_addr.push_back(mem.mem_addr);
            req_cyc.push_back(cyc);
        end
    end

    // Receiver samples every clock of every bit, so any bit-length error shows up.
    always begin
        @(negedge clk);
        if (!rst && txd === 1'b0) begin
            rx_s = cyc; rx_good = 1'b1; rx_b = '0; rx_v = 1'b0;
            for (int k = 0; k < 10; k++) begin
                for (int j = 0; j < B; j++) begin
                    if (k != 0 || j != 0) @(negedge clk);
                    if (j == 0) rx_v = txd;
                    else if (txd !== rx_v) rx_good = 1'b0;
                end
                if (k == 0 && rx_v !== 1'b0) rx_good = 1'b0;
                if (k == 9 && rx_v !== 1'b1) rx_good = 1'b0;
                if (k >= 1 && k <= 8) rx_b[k-1] = rx_v;
            end
            rx_byte.push_back(rx_b); rx_cyc.push_back(rx_s); rx_ok.push_back(rx_good);
        end
    end

    task automatic clear_logs();
        rx_byte.delete(); rx_cyc.delete(); rx_ok.delete();
        req_addr.delete(); req_cyc.delete();
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n, output int t);
        @(negedge clk);
        start = 1'b1; base = b; nwords = n; t = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int ndone, output int dcyc);
        ndone = 0; dcyc = -1;
        for (int i = 0; i < limit; i++) begin
            if (done === 1'b1) begin ndone++; dcyc = cyc; end
            if (ndone > 0 && busy === 1'b0) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", txd); end
        n_tests++; if (mem.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", mem.mem_req); end
        n_tests++; if (mem.mem_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", mem.mem_addr); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_word();
        int t, nd, dc;
        ram[16'h10] = 32'h44332211;
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
        clear_logs();
        pulse_start(14'h10, 15'd1, t);
        wait_done(400, nd, dc);
        n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL single_done_count: got %0d want 1", nd); end
        n_tests++; if (dc !== t + 164) begin n_fail++; $display("FAIL single_done_cycle: got %0d want %0d", dc, t + 164); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b want 0", busy); end
        n_tests++;
        if (req_cyc.size() != 1) begin n_fail++; $display("FAIL single_req_count: got %0d want 1", req_cyc.size()); end
        else if (req_cyc[0] !== t + 1 || req_addr[0] !== 14'h10) begin
            n_fail++; $display("FAIL single_req: got cyc %0d addr %h want cyc %0d addr 10", req_cyc[0], req_addr[0], t + 1);
        end
        n_tests++;
        if (rx_byte.size() != 4) begin n_fail++; $display("FAIL single_nbytes: got %0d want 4", rx_byte.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (rx_byte[i] !== exp_b[i] || rx_cyc[i] !== t + 3 + FRAME * i || !rx_ok[i]) begin
                    n_fail++;
                    $display("FAIL single_byte%0d: got %h at %0d ok=%0d want %h at %0d ok=1",
                             i, rx_byte[i], rx_cyc[i], rx_ok[i], exp_b[i], t + 3 + FRAME * i);
                end
            end
        end
    endtask

    task automatic test_zero_length();
        int t, lows;
        clear_logs();
        pulse_start(14'h5, 15'd0, t);
        n_tests++; if (done !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL zero_t1: got done=%b busy=%b want 1 1", done, busy); end
        @(negedge clk);
        n_tests++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_t2: got done=%b busy=%b want 0 0", done, busy); end
        lows = 0;
        repeat (20) begin @(negedge clk); if (txd !== 1'b1) lows++; end
        n_tests++; if (lows != 0) begin n_fail++; $display("FAIL zero_txd: got %0d low cycles want 0", lows); end
        n_tests++; if (req_addr.size() != 0) begin n_fail++; $display("FAIL zero_req: got %0d reads want 0", req_addr.size()); end
    endtask

    task automatic test_addr_wrap();
        int t, nd, dc;
        ram[16'h3FFF] = 32'hA5A5A5A5;
        ram[0]        = 32'h5A5A5A5A;
        clear_logs();
        pulse_start(14'h3FFF, 15'd2, t);
        wait_done(800, nd, dc);
        n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL wrap_done: got %0d want 1", nd); end
        n_tests++;
        if (req_addr.size() != 2) begin n_fail++; $display("FAIL wrap_nreq: got %0d want 2", req_addr.size()); end
        else if (req_addr[0] !== 14'h3FFF || req_addr[1] !== 14'h0000) begin
            n_fail++; $display("FAIL wrap_addr: got %h %h want 3fff 0000", req_addr[0], req_addr[1]);
        end
        n_tests++;
        if (rx_byte.size() != 8) begin n_fail++; $display("FAIL wrap_nbytes: got %0d want 8", rx_byte.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if (rx_byte[i] !== (i < 4 ? 8'hA5 : 8'h5A) || !rx_ok[i]) begin
                    n_fail++; $display("FAIL wrap_byte%0d: got %h ok=%0d want %h", i, rx_byte[i], rx_ok[i], (i < 4 ? 8'hA5 : 8'h5A));
                end
            end
            n_tests++;
            if (rx_cyc[4] !== rx_cyc[3] + FRAME + 3) begin
                n_fail++; $display("FAIL wrap_gap: got start %0d want %0d", rx_cyc[4], rx_cyc[3] + FRAME + 3);
            end
        end
    endtask

    task automatic test_flow_control();
        int t, c, lows, nd, dc;
        ram[16'h40] = 32'h87654321;
        exp_b[0] = 8'h21; exp_b[1] = 8'h43; exp_b[2] = 8'h65; exp_b[3] = 8'h87;
        clear_logs();
        cts_n = 1'b1;
        pulse_start(14'h40, 15'd1, t);
        lows = 0;
        repeat (50) begin @(negedge clk); if (txd !== 1'b1) lows++; end
        n_tests++; if (lows != 0 || busy !== 1'b1) begin n_fail++; $display("FAIL cts_hold: got %0d low cycles busy=%b want 0 1", lows, busy); end
        cts_n = 1'b0; c = cyc;
        repeat (6) @(negedge clk);  cts_n = 1'b1;
        repeat (10) @(negedge clk); cts_n = 1'b0;
        repeat (8) @(negedge clk);  cts_n = 1'b1;
        repeat (4) @(negedge clk);  cts_n = 1'b0;
        wait_done(400, nd, dc);
        n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL cts_done: got %0d want 1", nd); end
        n_tests++;
        if (rx_byte.size() != 4) begin n_fail++; $display("FAIL cts_nbytes: got %0d want 4", rx_byte.size()); end
        else begin
            n_tests++; if (rx_cyc[0] !== c + 1) begin n_fail++; $display("FAIL cts_first_start: got %0d want %0d", rx_cyc[0], c + 1); end
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (rx_byte[i] !== exp_b[i] || rx_cyc[i] !== c + 1 + FRAME * i || !rx_ok[i]) begin
                    n_fail++;
                    $display("FAIL cts_byte%0d: got %h at %0d ok=%0d want %h at %0d ok=1",
                             i, rx_byte[i], rx_cyc[i], rx_ok[i], exp_b[i], c + 1 + FRAME * i);
                end
            end
        end
    endtask

    task automatic test_busy_start();
        int t, g;
        ram[16'h10] = 32'h44332211;
        ram[16'h11] = 32'hDDCCBBAA;
        ram[16'h20] = 32'hFFFFFFFF;
        ram[16'h30] = 32'h00000000;
        clear_logs();
        pulse_start(14'h10, 15'd2, t);
        repeat (20) @(negedge clk);
        start = 1'b1; base = 14'h20; nwords = 15'd1;
        @(negedge clk);
        start = 1'b0;
        g = 0;
        while (cyc < t + 327 && g < 1000) begin @(negedge clk); g++; end
        n_tests++; if (done !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL busy_done_cycle: got done=%b busy=%b want 1 1", done, busy); end
        start = 1'b1; base = 14'h30; nwords = 15'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_restart: got busy=%b want 0", busy); end
        n_tests++;
        if (req_addr.size() != 2) begin n_fail++; $display("FAIL busy_nreq: got %0d want 2", req_addr.size()); end
        else if (req_addr[0] !== 14'h10 || req_addr[1] !== 14'h11) begin
            n_fail++; $display("FAIL busy_addr: got %h %h want 0010 0011", req_addr[0], req_addr[1]);
        end
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
        exp_b[4] = 8'hAA; exp_b[5] = 8'hBB; exp_b[6] = 8'hCC; exp_b[7] = 8'hDD;
        n_tests++;
        if (rx_byte.size() != 8) begin n_fail++; $display("FAIL busy_nbytes: got %0d want 8", rx_byte.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if (rx_byte[i] !== exp_b[i]) begin n_fail++; $display("FAIL busy_byte%0d: got %h want %h", i, rx_byte[i], exp_b[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int t, g, nd, dc;
        ram[16'h10] = 32'h44332211;
        ram[16'h11] = 32'hDDCCBBAA;
        clear_logs();
        pulse_start(14'h10, 15'd1, t);
        g = 0;
        while (cyc < t + 12 && g < 100) begin @(negedge clk); g++; end
        n_tests++; if (txd !== 1'b0) begin n_fail++; $display("FAIL rstmid_pre: got txd=%b want 0", txd); end
        rst = 1'b1;
        #1;
        n_tests++; if (txd !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_now: got txd=%b busy=%b want 1 0", txd, busy); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        clear_logs();
        pulse_start(14'h11, 15'd1, t);
        wait_done(400, nd, dc);
        exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC; exp_b[3] = 8'hDD;
        n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL rstmid_after_done: got %0d want 1", nd); end
        n_tests++;
        if (rx_byte.size() != 4) begin n_fail++; $display("FAIL rstmid_nbytes: got %0d want 4", rx_byte.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (rx_byte[i] !== exp_b[i] || rx_cyc[i] !== t + 3 + FRAME * i || !rx_ok[i]) begin
                    n_fail++; $display("FAIL rstmid_byte%0d: got %h at %0d want %h at %0d", i, rx_byte[i], rx_cyc[i], exp_b[i], t + 3 + FRAME * i);
                end
            end
        end
    endtask

    task automatic test_full_image();
        int t, nd, dc, bad_b, bad_a, bad_f;
        logic [31:0] w;
        logic [7:0]  e;
        for (int i = 0; i < 256; i++) ram[4096 + i] = $urandom;
        clear_logs();
        pulse_start(14'h1000, 15'd256, t);
        wait_done(256 * 170 + 200, nd, dc);
        n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL image_done: got %0d want 1", nd); end
        n_tests++;
        if (req_addr.size() != 256) begin n_fail++; $display("FAIL image_nreq: got %0d want 256", req_addr.size()); end
        else begin
            bad_a = 0;
            for (int i = 0; i < 256; i++) if (req_addr[i] !== 14'(4096 + i)) bad_a++;
            n_tests++; if (bad_a != 0) begin n_fail++; $display("FAIL image_addr: got %0d wrong addresses want 0", bad_a); end
        end
        n_tests++;
        if (rx_byte.size() != 1024) begin n_fail++; $display("FAIL image_nbytes: got %0d want 1024", rx_byte.size()); end
        else begin
            bad_b = 0; bad_f = 0;
            for (int i = 0; i < 1024; i++) begin
                w = ram[4096 + i / 4];
                e = w[8 * (i % 4) +: 8];
                if (rx_byte[i] !== e) bad_b++;
                if (!rx_ok[i]) bad_f++;
            end
            n_tests++; if (bad_b != 0) begin n_fail++; $display("FAIL image_bytes: got %0d wrong bytes want 0", bad_b); end
            n_tests++; if (bad_f != 0) begin n_fail++; $display("FAIL image_frames: got %0d bad frames want 0", bad_f); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_word();
        test_zero_length();
        test_addr_wrap();
        test_flow_control();
        test_busy_start();
        test_reset_mid();
        test_full_image();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
